// File: rtl/ls_data_gen.sv
// Serial test-pattern generator for the chip under test. D_OUT drives the chip, and DATA/DATA_VLD
// carry the same stream, delayed by LAT cycles, to the comparator.
module ls_data_gen #(
  parameter int DLY_MAX = 16,  // 2..16
  parameter int LEN_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [1:0]       MODE,
  input  logic [6:0]       SEED,
  input  logic [LEN_W-1:0] NUM_BITS,
  input  logic [3:0]       LAT,
  output logic             D_OUT,
  output logic             DATA,
  output logic             DATA_VLD,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

  localparam logic [3:0]       LAT_MAX = 4'(DLY_MAX - 1);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  // Every pattern is a 7-bit state plus an output tap and a step rule.
  function automatic logic pat_bit(input logic [1:0] mode, input logic [6:0] s);
    case (mode)
      2'd0:    pat_bit = s[6];
      2'd2:    pat_bit = 1'b1;
      default: pat_bit = s[0];
    endcase
  endfunction

  function automatic logic [6:0] pat_next(input logic [1:0] mode, input logic [6:0] s);
    case (mode)
      2'd0:    pat_next = {s[5:0], s[6] ^ s[5]};
      2'd1:    pat_next = {s[6:1], ~s[0]};
      2'd2:    pat_next = s;
      default: pat_next = {s[0], s[6:1]};
    endcase
  endfunction

  function automatic logic [6:0] pat_init(input logic [1:0] mode, input logic [6:0] seed);
    case (mode)
      2'd0:    pat_init = (seed == 7'd0) ? 7'h01 : seed;
      2'd1:    pat_init = 7'h00;
      default: pat_init = seed;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [LEN_W-1:0]   num_q, num_d;
  logic [3:0]         lat_q, lat_d;
  logic [6:0]         pat_q, pat_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               dout_q, dout_d;
  logic [DLY_MAX-1:1] dly_q, dly_d;
  logic [DLY_MAX-1:1] vdly_q, vdly_d;

  logic [3:0]         lat_in;
  logic [6:0]         init_pat;
  logic               run_vld;
  logic [DLY_MAX-1:0] dtap;
  logic [DLY_MAX-1:0] vtap;

  if (DLY_MAX >= 16) begin : g_lat_full
    assign lat_in = LAT;
  end else begin : g_lat_clamp
    assign lat_in = (LAT > LAT_MAX) ? LAT_MAX : LAT;
  end

  assign init_pat = pat_init(MODE, SEED);
  assign run_vld  = (state_q == S_RUN);
  // Tap 0 is the live D_OUT so LAT=0 needs no special case.
  assign dtap     = {dly_q, dout_q};
  assign vtap     = {vdly_q, run_vld};

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    num_d   = num_q;
    lat_d   = lat_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    dout_d  = 1'b0;
    dly_d   = dtap[DLY_MAX-2:0];
    vdly_d  = vtap[DLY_MAX-2:0];

    case (state_q)
      S_IDLE: begin
        if (START) begin
          mode_d = MODE;
          num_d  = NUM_BITS;
          lat_d  = lat_in;
          cnt_d  = '0;
          dly_d  = '0;
          vdly_d = '0;
          pat_d  = init_pat;
          if (NUM_BITS == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            dout_d  = pat_bit(MODE, init_pat);
            pat_d   = pat_next(MODE, init_pat);
          end
        end
      end
      S_RUN: begin
        if (cnt_q == (num_q - ONE)) begin
          cnt_d   = '0;
          state_d = (lat_q == 4'd0) ? S_DONE : S_FLUSH;
        end else begin
          cnt_d  = cnt_q + ONE;
          dout_d = pat_bit(mode_q, pat_q);
          pat_d  = pat_next(mode_q, pat_q);
        end
      end
      S_FLUSH: begin
        // The counter is reused to time the drain of the delay line.
        if (cnt_q == (LEN_W'(lat_q) - ONE)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ABORT) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      dout_d  = 1'b0;
      dly_d   = '0;
      vdly_d  = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      num_q   <= '0;
      lat_q   <= 4'd0;
      pat_q   <= 7'h01;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      dly_q   <= '0;
      vdly_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      num_q   <= num_d;
      lat_q   <= lat_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dly_q   <= dly_d;
      vdly_q  <= vdly_d;
    end
  end

  assign D_OUT    = dout_q;
  assign DATA_VLD = vtap[lat_q];
  assign DATA     = dtap[lat_q] & DATA_VLD;
  assign BUSY     = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign DONE     = (state_q == S_DONE);

endmodule

// File: tb/tb_ls_data_gen.sv
// Bench for ls_data_gen: directed and randomized bursts checked cycle by cycle against a
// timeline model built from the pattern rules, latency, abort and reset behaviour.
module tb_ls_data_gen;
  localparam int LW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic          ABORT;
  logic [1:0]    MODE;
  logic [6:0]    SEED;
  logic [LW-1:0] NUM_BITS;
  logic [3:0]    LAT;
  logic          D_OUT, DATA, DATA_VLD, BUSY, DONE;

  int vectors     = 0;
  int miscompares = 0;
  bit obs_q[$];

  always #5 CLK = ~CLK;

  ls_data_gen #(.DLY_MAX(16), .LEN_W(LW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .MODE(MODE), .SEED(SEED),
    .NUM_BITS(NUM_BITS), .LAT(LAT), .D_OUT(D_OUT), .DATA(DATA), .DATA_VLD(DATA_VLD),
    .BUSY(BUSY), .DONE(DONE)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " dout"}, D_OUT, 0);
    chk({tag, " data"}, DATA, 0);
    chk({tag, " vld"}, DATA_VLD, 0);
    chk({tag, " busy"}, BUSY, 0);
    chk({tag, " done"}, DONE, 0);
  endtask

  // Entered just after a negedge. abort_t > 0 raises ABORT during that burst cycle.
  task automatic burst(input logic [1:0] m, input logic [6:0] s, input int n, input int l,
                       input int abort_t);
    bit         eb[$];
    logic [6:0] r;
    bit         aborted;
    logic       e_dout, e_vld, e_data, e_busy, e_done;
    int         done_t, last_poke;
    r = (s == 7'd0) ? 7'h01 : s;
    for (int k = 0; k < n; k++) begin
      case (m)
        2'd0: begin
          eb.push_back(r[6]);
          r = {r[5:0], r[6] ^ r[5]};
        end
        2'd1:    eb.push_back(k % 2 == 1);
        2'd2:    eb.push_back(1'b1);
        default: eb.push_back(s[k % 7]);
      endcase
    end
    done_t    = (n == 0) ? 1 : n + l + 1;
    last_poke = (abort_t > 0) ? abort_t : done_t;
    obs_q.delete();

    START = 1'b1; MODE = m; SEED = s; NUM_BITS = LW'(n); LAT = 4'(l);
    @(negedge CLK);
    for (int t = 1; t <= n + l + 3; t++) begin
      aborted = (abort_t > 0) && (t > abort_t);
      e_dout  = !aborted && (t <= n) ? eb[t-1] : 1'b0;
      e_vld   = !aborted && (t > l) && (t <= n + l);
      e_data  = e_vld ? eb[t-1-l] : 1'b0;
      e_busy  = !aborted && (n > 0) && (t <= n + l);
      e_done  = !aborted && (t == done_t);
      chk($sformatf("m%0d n%0d l%0d t%0d dout", m, n, l, t), D_OUT, e_dout);
      chk($sformatf("m%0d n%0d l%0d t%0d data", m, n, l, t), DATA, e_data);
      chk($sformatf("m%0d n%0d l%0d t%0d vld", m, n, l, t), DATA_VLD, e_vld);
      chk($sformatf("m%0d n%0d l%0d t%0d busy", m, n, l, t), BUSY, e_busy);
      chk($sformatf("m%0d n%0d l%0d t%0d done", m, n, l, t), DONE, e_done);
      if (t <= n) obs_q.push_back(D_OUT);
      // Scramble the config inputs and poke START while it must be ignored.
      ABORT    = (t == abort_t);
      START    = (t <= last_poke) ? 1'($urandom_range(0, 1)) : 1'b0;
      MODE     = 2'($urandom);
      SEED     = 7'($urandom);
      NUM_BITS = LW'($urandom);
      LAT      = 4'($urandom);
      @(negedge CLK);
    end
    START = 1'b0;
    ABORT = 1'b0;
  endtask

  initial begin
    int ones;
    int n, l, ab;
    RST = 1'b1; START = 1'b0; ABORT = 1'b0; MODE = 2'd0; SEED = 7'd0; NUM_BITS = '0; LAT = 4'd0;
    repeat (2) @(negedge CLK);
    chk_idle("reset");
    RST = 1'b0;
    @(negedge CLK);

    burst(2'd0, 7'h01, 20, 0, 0);
    burst(2'd1, 7'h5a, 8, 3, 0);

    burst(2'd0, 7'h00, 254, 5, 0);
    ones = 0;
    for (int i = 0; i < 127; i++) ones += int'(obs_q[i]);
    chk("prbs ones period0", ones, 64);
    ones = 0;
    for (int i = 127; i < 254; i++) ones += int'(obs_q[i]);
    chk("prbs ones period1", ones, 64);

    burst(2'd3, 7'b1000110, 14, 1, 0);
    burst(2'd0, 7'h35, 20, 4, 6);
    burst(2'd0, 7'h35, 20, 4, 0);
    burst(2'd1, 7'h11, 0, 5, 0);
    burst(2'd2, 7'h00, 255, 15, 0);
    burst(2'd3, 7'h7f, 1, 15, 0);

    for (int i = 0; i < 30; i++) begin
      n  = $urandom_range(0, 40);
      l  = $urandom_range(0, 15);
      ab = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n + l) : 0;
      burst(2'($urandom), 7'($urandom), n, l, ab);
    end

    // Asynchronous reset in the middle of a burst.
    START = 1'b1; MODE = 2'd2; SEED = 7'h00; NUM_BITS = LW'(30); LAT = 4'd3;
    @(negedge CLK);
    START = 1'b0;
    repeat (8) @(negedge CLK);
    chk("pre-rst busy", BUSY, 1);
    #2 RST = 1'b1;
    #1 chk_idle("async rst");
    @(negedge CLK);
    RST = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge CLK);
      chk_idle($sformatf("post-rst t%0d", t));
    end
    burst(2'd0, 7'h2c, 16, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ls_data_gen.md
Name: ls_data_gen

Overview:
- Stimulus-side counterpart of the error counter. Generates a serial test pattern on D_OUT, which drives the test chip input.
- Emits the same bit stream on DATA, delayed by a programmable latency so it lines up with the chip's returned Q at the comparator.
- Runs a bounded burst of NUM_BITS bits per START, then reports DONE.

Parameters:
- DLY_MAX, 16, depth of the expected-data delay line. Usable LAT range is 0..DLY_MAX-1.
- LEN_W, 16, width of the burst length and bit counter.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- START  in  1  begin a burst; sampled only in IDLE
- ABORT  in  1  terminate immediately from any state
- MODE  in  2  pattern select, latched at START
- SEED  in  7  PRBS seed or walk word, latched at START
- NUM_BITS  in  LEN_W  burst length in bits, latched at START
- LAT  in  4  chip latency in cycles, latched at START
- D_OUT  out  1  registered pattern bit to test chip
- DATA  out  1  expected bit to comparator (D_OUT delayed LAT cycles)
- DATA_VLD  out  1  DATA is part of the burst (comparison window)
- BUSY  out  1  high in RUN and FLUSH
- DONE  out  1  one-cycle pulse at end of burst

Behaviour:
- Reset (async, RST=1):
  - State to IDLE.
  - D_OUT, DATA, DATA_VLD, BUSY, DONE all 0.
  - LFSR = 7'h01, bit counter 0, delay line cleared.
- IDLE:
  - START=1 latches MODE, SEED, NUM_BITS and LAT. LAT above DLY_MAX-1 clamps to DLY_MAX-1.
  - LFSR loads SEED, or 7'h01 if SEED==0.
  - NUM_BITS==0: go straight to DONE state, no bits driven.
  - Otherwise go to RUN.
- RUN:
  - Bit 0 appears on D_OUT in the first RUN cycle (one cycle after START sampled).
  - Each cycle the pattern advances, the counter increments, and D_OUT registers the new bit.
  - After bit NUM_BITS-1 is driven, go to FLUSH.
- FLUSH:
  - D_OUT=0.
  - Hold for LAT cycles (0 cycles if LAT=0) so the delay line drains, then go to DONE state.
- DONE state: DONE=1 for exactly one cycle, BUSY=0, return to IDLE.
- START outside IDLE is ignored. START in the DONE-state cycle is also ignored.
- Patterns (MODE):
  - 0 PRBS7, x^7+x^6+1. bit = lfsr[6]; next = {lfsr[5:0], lfsr[6]^lfsr[5]}. Period 127, free-running across the burst.
  - 1 Alternating 0,1,0,1..., starting with 0.
  - 2 All ones.
  - 3 Walk: SEED bits output LSB first, repeating every 7 bits.
- Delay line:
  - DATA = D_OUT from LAT cycles earlier; LAT=0 gives DATA == D_OUT in the same cycle.
  - DATA_VLD = (RUN-bit valid) delayed by the same LAT, so it is high for exactly NUM_BITS consecutive cycles per burst.
  - DATA and DATA_VLD are 0 outside the window.
- Counter:
  - LEN_W bits, compares against NUM_BITS-1.
  - NUM_BITS = 2^LEN_W-1 must complete without wrap.
- ABORT:
  - Highest priority over START and over any state transition.
  - Next cycle: IDLE, D_OUT/DATA/DATA_VLD/BUSY = 0, delay line cleared, no DONE pulse.
- RST mid-burst: same outputs as ABORT, no DONE pulse.
- BUSY: high from the first RUN cycle through the last FLUSH cycle.

Test Plan:
- MODE=0, SEED=7'h01, NUM_BITS=20, LAT=0 -> D_OUT bits 0..5 = 0, bit 6 = 1, bits 7..19 follow the LFSR. DATA==D_OUT each cycle, DATA_VLD high 20 cycles, DONE pulses once, the cycle after the last bit.
- MODE=1, NUM_BITS=8, LAT=3 -> D_OUT = 01010101. DATA repeats it 3 cycles later with DATA_VLD high 8 cycles. BUSY high 11 cycles. DONE follows the last DATA_VLD cycle.
- MODE=0, SEED=0, NUM_BITS=254 -> behaves as SEED=7'h01. D_OUT bits 127..253 equal bits 0..126; each 127-bit period contains 64 ones.
- MODE=3, SEED=7'b1000110, NUM_BITS=14, LAT=1 -> D_OUT = 0110001 0110001; DATA the same, one cycle later.
- ABORT asserted at bit 5 of a 20-bit burst with LAT=4 -> next cycle all outputs 0 and no DONE. A new START then runs a full burst from the SEED.
- NUM_BITS=0 START -> DONE pulse one cycle later, BUSY and DATA_VLD never high. START during RUN -> ignored, burst length unchanged.
